// File: rtl/bus_halt_monitor.sv
// rtl/bus_halt_monitor.sv - run-control monitor: halt detect, watchdog, watch channels, access counters
// Optional address history buffer is built when ADDR_HIST_EN is defined; otherwise HistAddr reads 0.
module bus_halt_monitor #(
    parameter int               AW         = 16,
    parameter int               NWATCH     = 2,
    parameter logic [AW-1:0]    HALT_ADDR  = 16'hFFFF,
    parameter int               HALT_HITS  = 1,
    parameter int               CW         = 32,
    parameter int               HIST_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [AW-1:0]                 Addr,
    input  logic                          RD,
    input  logic                          WR,
    input  logic                          Start,
    input  logic [CW-1:0]                 Timeout,
    input  logic [NWATCH*AW-1:0]          WatchAddr,
    input  logic [NWATCH-1:0]             WatchEn,
    output logic                          Done,
    output logic                          HaltHit,
    output logic                          TimedOut,
    output logic                          BusErr,
    output logic [NWATCH-1:0]             WatchHit,
    output logic [CW-1:0]                 CycleCnt,
    output logic [CW-1:0]                 RdCnt,
    output logic [CW-1:0]                 WrCnt,
    input  logic [$clog2(HIST_DEPTH)-1:0] HistIdx,
    output logic [AW-1:0]                 HistAddr
);

    localparam int HHW = (HALT_HITS > 1) ? $clog2(HALT_HITS + 1) : 1;
    localparam logic [HHW-1:0] HITS_TGT = HHW'(HALT_HITS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_HALTED   = 2'd2,
        S_TIMEDOUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [CW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     wr_q, wr_d;
    logic              berr_q, berr_d;
    logic [NWATCH-1:0] watch_q, watch_d;
    logic [HHW-1:0]    hits_q, hits_d;
    logic              halt_match;

    assign halt_match = (Addr == HALT_ADDR);

    // Next-state logic: Start always wins (restart), RUN samples the bus, other states hold.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        berr_d  = berr_q;
        watch_d = watch_q;
        hits_d  = hits_q;
        if (Start) begin
            state_d = S_RUN;
            cyc_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            berr_d  = 1'b0;
            watch_d = '0;
            hits_d  = '0;
        end else if (state_q == S_RUN) begin
            cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);
            // A simultaneous RD+WR is a bus error and is counted as a write only.
            if (WR) begin
                wr_d = (wr_q == '1) ? wr_q : wr_q + CW'(1);
                if (RD) begin
                    berr_d = 1'b1;
                end
            end else if (RD) begin
                rd_d = (rd_q == '1) ? rd_q : rd_q + CW'(1);
            end
            for (int i = 0; i < NWATCH; i++) begin
                if (WatchEn[i] && (RD || WR) && (Addr == WatchAddr[i*AW +: AW])) begin
                    watch_d[i] = 1'b1;
                end
            end
            // Run length of consecutive halt-address samples; non-zero implies the
            // previous sample was also the halt address.
            if (halt_match) begin
                if (hits_q == '0) begin
                    hits_d = HHW'(1);
                end else if (hits_q != HITS_TGT) begin
                    hits_d = hits_q + HHW'(1);
                end
            end else begin
                hits_d = '0;
            end
            // Halt takes priority over a watchdog expiry on the same edge.
            if (halt_match && (hits_d == HITS_TGT)) begin
                state_d = S_HALTED;
            end else if ((Timeout != '0) && (cyc_q == Timeout - CW'(1))) begin
                state_d = S_TIMEDOUT;
            end
        end
    end

    // State, counter and flag registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            berr_q  <= 1'b0;
            watch_q <= '0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            berr_q  <= berr_d;
            watch_q <= watch_d;
            hits_q  <= hits_d;
        end
    end

    assign HaltHit  = (state_q == S_HALTED);
    assign TimedOut = (state_q == S_TIMEDOUT);
    assign Done     = HaltHit || TimedOut;
    assign BusErr   = berr_q;
    assign WatchHit = watch_q;
    assign CycleCnt = cyc_q;
    assign RdCnt    = rd_q;
    assign WrCnt    = wr_q;

`ifdef ADDR_HIST_EN
    localparam int HIW = $clog2(HIST_DEPTH);

    logic [AW-1:0]  hist_q [HIST_DEPTH];
    logic [AW-1:0]  hist_d [HIST_DEPTH];
    logic [HIW-1:0] wptr_q, wptr_d;
    logic [AW-1:0]  prev_q, prev_d;
    logic           first_q, first_d;
    logic [HIW-1:0] rd_ptr;

    // History push: the first RUN sample always pushes, later ones only on address change.
    always_comb begin
        hist_d  = hist_q;
        wptr_d  = wptr_q;
        prev_d  = prev_q;
        first_d = first_q;
        if (Start) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_d[i] = '0;
            end
            wptr_d  = '0;
            prev_d  = '0;
            first_d = 1'b1;
        end else if (state_q == S_RUN) begin
            if (first_q || (Addr != prev_q)) begin
                hist_d[wptr_q] = Addr;
                wptr_d         = wptr_q + HIW'(1);
            end
            prev_d  = Addr;
            first_d = 1'b0;
        end
    end

    // History storage registers; cleared so unwritten entries read 0.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wptr_q  <= '0;
            prev_q  <= '0;
            first_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            wptr_q  <= wptr_d;
            prev_q  <= prev_d;
            first_q <= first_d;
        end
    end

    assign rd_ptr   = wptr_q - HIW'(1) - HistIdx;
    assign HistAddr = hist_q[rd_ptr];
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^HistIdx;
    assign HistAddr        = '0;
`endif

endmodule

// File: tb/tb_bus_halt_monitor.sv
// tb/tb_bus_halt_monitor.sv - scoreboard bench for bus_halt_monitor (HALT_HITS=3, CW=8)
module tb_bus_halt_monitor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Addr;
    logic        RD, WR, Start;
    logic [7:0]  Timeout;
    logic [31:0] WatchAddr;
    logic [1:0]  WatchEn;
    logic        Done, HaltHit, TimedOut, BusErr;
    logic [1:0]  WatchHit;
    logic [7:0]  CycleCnt, RdCnt, WrCnt;
    logic [2:0]  HistIdx;
    logic [15:0] HistAddr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       halt;
        logic       tout;
        logic       berr;
        logic [1:0] watch;
        logic [7:0] cyc;
        logic [7:0] rd;
        logic [7:0] wr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    bus_halt_monitor #(
        .AW(16), .NWATCH(2), .HALT_ADDR(16'hFFFF), .HALT_HITS(3), .CW(8), .HIST_DEPTH(8)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR), .Start(Start),
        .Timeout(Timeout), .WatchAddr(WatchAddr), .WatchEn(WatchEn),
        .Done(Done), .HaltHit(HaltHit), .TimedOut(TimedOut), .BusErr(BusErr),
        .WatchHit(WatchHit), .CycleCnt(CycleCnt), .RdCnt(RdCnt), .WrCnt(WrCnt),
        .HistIdx(HistIdx), .HistAddr(HistAddr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic halt, input logic tout, input logic berr,
                                input logic [1:0] watch, input logic [7:0] cyc,
                                input logic [7:0] rd, input logic [7:0] wr);
        exp_t e;
        e.halt = halt; e.tout = tout; e.berr = berr; e.watch = watch;
        e.cyc = cyc; e.rd = rd; e.wr = wr;
        return e;
    endfunction

    task automatic tick(input logic [15:0] a, input logic rd, input logic wr);
        Addr = a; RD = rd; WR = wr;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic start_run();
        Start = 1'b1;
        tick(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic halt3();
        for (int i = 0; i < 3; i++) tick(16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!Done && n < budget) begin
            tick(Addr, RD, WR);
            n++;
        end
        if (!Done) begin
            checks++;
            errors++;
            $display("FAIL wait_done no Done within %0d cycles", budget);
        end
    endtask

    // Monitor: on each rising Done, pop the expected end-of-run state and compare.
    always @(negedge Clk) begin
        if (Done && !done_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done actual=Done required=no_run_pending");
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_halthit", HaltHit, mon_e.halt);
                check("sb_timedout", TimedOut, mon_e.tout);
                check("sb_buserr", BusErr, mon_e.berr);
                check("sb_watchhit", WatchHit, mon_e.watch);
                check("sb_cyclecnt", CycleCnt, mon_e.cyc);
                check("sb_rdcnt", RdCnt, mon_e.rd);
                check("sb_wrcnt", WrCnt, mon_e.wr);
            end
        end
        done_prev = Done;
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Addr = '0; RD = 0; WR = 0;
        Timeout = 8'd0; WatchAddr = '0; WatchEn = '0; HistIdx = '0;
        tick(16'h0000, 0, 0);
        tick(16'h0000, 0, 0);
        check("reset_flags", {Done, HaltHit, TimedOut, BusErr, WatchHit}, 0);
        check("reset_counts", {CycleCnt, RdCnt, WrCnt}, 0);
        check("reset_hist", HistAddr, 0);
        Reset_n = 1'b1;

        // Mid-run reset, also asserted together with Start
        WatchAddr = {16'h0000, 16'h0040}; WatchEn = 2'b01;
        start_run();
        for (int i = 0; i < 3; i++) tick(16'h0040, 1, 1);
        check("run_before_reset_cyc", CycleCnt, 3);
        Reset_n = 1'b0;
        Start = 1'b1; tick(16'h0040, 1, 1);
        Start = 1'b1; tick(16'h0040, 1, 1);
        Reset_n = 1'b1;
        check("midreset_flags", {Done, HaltHit, TimedOut, BusErr, WatchHit}, 0);
        check("midreset_counts", {CycleCnt, RdCnt, WrCnt}, 0);
        tick(16'h0040, 1, 0);
        tick(16'h0040, 1, 0);
        check("idle_holds_counts", {CycleCnt, RdCnt, WrCnt}, 0);
        check("idle_not_done", Done, 0);

        // Halt after 10 ordinary cycles plus 3 halt samples
        WatchEn = 2'b00;
        sb_q.push_back(mk(1, 0, 0, 2'b00, 8'd13, 8'd0, 8'd0));
        start_run();
        for (int i = 1; i <= 10; i++) tick(16'(i), 0, 0);
        halt3();
        wait_done(4);
        for (int i = 0; i < 5; i++) tick(16'h0055, 1, 0);
        check("halted_frozen_cyc", CycleCnt, 13);
        check("halted_frozen_rd", RdCnt, 0);
        check("halted_stays_done", {Done, HaltHit}, 2'b11);

        // Interrupted halt run: qualifies only on the 6th sample
        sb_q.push_back(mk(1, 0, 0, 2'b00, 8'd6, 8'd0, 8'd0));
        start_run();
        tick(16'hFFFF, 0, 0); tick(16'hFFFF, 0, 0); tick(16'h0000, 0, 0);
        tick(16'hFFFF, 0, 0); tick(16'hFFFF, 0, 0);
        check("hits_no_early_halt", Done, 0);
        tick(16'hFFFF, 0, 0);
        wait_done(4);

        // Watchdog Timeout=5
        Timeout = 8'd5;
        sb_q.push_back(mk(0, 1, 0, 2'b00, 8'd5, 8'd0, 8'd0));
        start_run();
        Addr = 16'h0100; RD = 0; WR = 0;
        wait_done(20);

        // Timeout=0 never expires; counters saturate
        Timeout = 8'd0;
        start_run();
        for (int i = 0; i < 300; i++) tick(16'h0200, 1, 0);
        check("no_timeout_done", Done, 0);
        check("sat_cyclecnt", CycleCnt, 8'hFF);
        check("sat_rdcnt", RdCnt, 8'hFF);
        for (int i = 0; i < 5; i++) tick(16'h0204, 0, 1);
        check("wr_count_sat_cyc", {WrCnt, CycleCnt}, {8'd5, 8'hFF});

        // Halt and timeout on the same edge (restart from RUN)
        Timeout = 8'd3;
        sb_q.push_back(mk(1, 0, 0, 2'b00, 8'd3, 8'd0, 8'd0));
        start_run();
        check("restart_clears", {CycleCnt, RdCnt, WrCnt}, 0);
        halt3();
        wait_done(4);

        // Watch channel 0, bus error counts as write only
        Timeout = 8'd0;
        WatchAddr = {16'h0080, 16'h0040}; WatchEn = 2'b11;
        sb_q.push_back(mk(1, 0, 1, 2'b01, 8'd7, 8'd1, 8'd2));
        start_run();
        tick(16'h0040, 1, 0);
        tick(16'h0040, 1, 1);
        check("buserr_rd_unchanged", {BusErr, RdCnt, WrCnt}, {1'b1, 8'd1, 8'd1});
        tick(16'h0080, 0, 0);
        tick(16'h0020, 0, 1);
        halt3();
        wait_done(4);

        // Disabled channel ignored; flags cleared by Start
        WatchAddr = {16'h0040, 16'h0040}; WatchEn = 2'b10;
        sb_q.push_back(mk(1, 0, 0, 2'b10, 8'd4, 8'd1, 8'd0));
        start_run();
        tick(16'h0040, 1, 0);
        halt3();
        wait_done(4);

        // Both channels on the same edge
        WatchEn = 2'b11;
        sb_q.push_back(mk(1, 0, 0, 2'b11, 8'd4, 8'd0, 8'd1));
        start_run();
        tick(16'h0040, 0, 1);
        halt3();
        wait_done(4);

        // Address history over 10 distinct addresses
        WatchEn = 2'b00;
        sb_q.push_back(mk(1, 0, 0, 2'b00, 8'd13, 8'd0, 8'd0));
        start_run();
        for (int i = 0; i < 10; i++) tick(16'h1000 + 16'(i), 0, 0);
        HistIdx = 3'd0; #1;
`ifdef ADDR_HIST_EN
        check("hist_idx0", HistAddr, 16'h1009);
        HistIdx = 3'd1; #1;
        check("hist_idx1", HistAddr, 16'h1008);
        HistIdx = 3'd7; #1;
        check("hist_idx7", HistAddr, 16'h1002);
`else
        check("hist_idx0_tied", HistAddr, 16'h0000);
        HistIdx = 3'd7; #1;
        check("hist_idx7_tied", HistAddr, 16'h0000);
`endif
        halt3();
        wait_done(4);

        tick(16'h0000, 0, 0);
        tick(16'h0000, 0, 0);
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
